sipo_deserializer: RTL

Serial-to-parallel deserializer that sits directly downstream of the PISO serializer and reassembles its bit stream into WIDTH-bit words. It samples one bit per enabled clock cycle, places it according to SHIFT_DIR, and presents each completed word on a registered parallel output with a valid/ready handshake. A single-entry holding register decouples word assembly from the consumer. Overruns are flagged, and a sync input re-aligns word boundaries.

---
 rtl/sipo_deserializer_if.sv | 24 ++
 rtl/sipo_deserializer.sv | 80 ++++++++
 2 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle for the deserializer.
// master drives the bit stream and ready; slave is the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             in;
    logic             enable;
    logic             sync;
    logic             ready;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output in, enable, sync, ready,
        input  out, valid, busy, overrun
    );

    modport slave (
        input  in, enable, sync, ready,
        output out, valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a single-entry holding register,
// valid/ready output handshake, overrun pulse and word-boundary sync.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_next;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             overrun_q;
    logic             complete;
    logic             load;
    int               pos;

    // A sync edge restarts the word, so the sampled bit is bit 0.
    always_comb begin
        pos = bus.sync ? 0 : int'(bit_count);
        if (SHIFT_DIR)
            pos = WIDTH - 1 - pos;
        asm_next = asm_q;
        for (int i = 0; i < WIDTH; i++)
            if (i == pos)
                asm_next[i] = bus.in;
    end

    // Word completion, holding-register load and bit-count update.
    always_comb begin
        complete = bus.enable && !bus.sync && (bit_count == LAST);
        load     = complete && (!valid_q || bus.ready);
        count_next = bit_count;
        if (bus.sync)
            count_next = bus.enable ? CW'(1) : '0;
        else if (bus.enable)
            count_next = complete ? '0 : bit_count + CW'(1);
    end

    // Assembly register and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q     <= '0;
            bit_count <= '0;
        end else begin
            bit_count <= count_next;
            if (bus.enable)
                asm_q <= asm_next;
        end
    end

    // Holding register, handshake and overrun pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= complete && !load;
            if (load) begin
                out_q   <= asm_next;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = (bit_count != '0);
    assign bus.overrun = overrun_q;
endmodule
